imem_loader: RTL and testbench

Program loader that writes the instruction memory from the producer side of the MIPS instruction format the control decoder consumes. It accepts instruction descriptions (class plus fields) over a valid/ready handshake, encodes each into a 32-bit MIPS word, buffers it, and writes it sequentially to the instruction-memory write port starting at a programmed base word address. It sits between the test/boot host and the instruction memory, ahead of the single-cycle datapath.

---
 rtl/instr_pkg.sv | 57 +++++
 rtl/imem_loader_if.sv | 40 ++++
 rtl/instr_fifo.sv | 45 ++++
 rtl/imem_loader.sv | 134 +++++++++++++
 tb/tb_imem_loader.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_pkg.sv
// Shared types for the instruction-memory loader: instruction classes, MIPS opcodes,
// loader FSM states and the class+fields -> 32-bit word encoder.
package instr_pkg;

    localparam int KIND_W = 3;

    typedef enum logic [KIND_W-1:0] {
        K_RTYPE = 3'd0,
        K_LW    = 3'd1,
        K_SW    = 3'd2,
        K_BEQ   = 3'd3,
        K_ADDI  = 3'd4,
        K_J     = 3'd5
    } kind_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    function automatic logic kind_legal(input logic [KIND_W-1:0] kind);
        return kind <= K_J;
    endfunction

    // Illegal classes fall through to an all-zero word, which is a MIPS nop.
    function automatic logic [31:0] encode(
        input logic [KIND_W-1:0] kind,
        input logic [4:0]        rs,
        input logic [4:0]        rt,
        input logic [4:0]        rd,
        input logic [5:0]        funct,
        input logic [15:0]       imm,
        input logic [25:0]       target
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        case (kind)
            K_RTYPE: w = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
            K_LW:    w = {OP_LW,   rs, rt, imm};
            K_SW:    w = {OP_SW,   rs, rt, imm};
            K_BEQ:   w = {OP_BEQ,  rs, rt, imm};
            K_ADDI:  w = {OP_ADDI, rs, rt, imm};
            K_J:     w = {OP_J,    target};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host-side handshake plus instruction-memory write port of the loader.
// slave = loader side, master = host / memory side.
interface imem_loader_if
    import instr_pkg::*;
#(
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [KIND_W-1:0] in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [5:0]        in_funct;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              mem_busy;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wd;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   count;
    logic              err;

    modport slave (
        input  start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
               in_funct, in_imm, in_target, mem_busy,
        output in_ready, mem_we, mem_addr, mem_wd, busy, done, count, err
    );

    modport master (
        output start, base_addr, in_valid, in_last, in_kind, in_rs, in_rt, in_rd,
               in_funct, in_imm, in_target, mem_busy,
        input  in_ready, mem_we, mem_addr, mem_wd, busy, done, count, err
    );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded instruction words; pointers carry an extra wrap bit
// so full and empty are distinguishable without a counter.
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign rdata   = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Encodes instruction descriptions into MIPS words and writes them sequentially into
// instruction memory. Define IMEM_LOADER_CHECK_EN to drop illegal classes and flag err.
//
//   state   | meaning
//   S_IDLE  | no session; waiting for start
//   S_LOAD  | accepting descriptions until one with in_last
//   S_DRAIN | input closed; flushing FIFO and output register
module imem_loader
    import instr_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input logic          clk,
    input logic          reset,
    imem_loader_if.slave bus
);
`ifdef IMEM_LOADER_CHECK_EN
    localparam int FW = 33;
`else
    localparam int FW = 32;
`endif
    localparam logic [ADDR_W:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic              push, pop, fifo_full, fifo_empty;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;
    logic [31:0]       word, head_word;
    logic              head_drop, head_load, retire, out_free;
    logic              out_valid;
    logic [31:0]       wd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              done_q;

    assign word = encode(bus.in_kind, bus.in_rs, bus.in_rt, bus.in_rd,
                         bus.in_funct, bus.in_imm, bus.in_target);

    assign bus.in_ready = (state_q == S_LOAD) && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;

`ifdef IMEM_LOADER_CHECK_EN
    logic err_q;
    logic illegal;

    // Illegal entries travel through the FIFO tagged so they are retired without a write.
    assign illegal    = !kind_legal(bus.in_kind);
    assign fifo_wdata = {illegal, word};
    assign head_word  = fifo_rdata[31:0];
    assign head_drop  = !fifo_empty && fifo_rdata[32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state_q == S_IDLE && bus.start) begin
            err_q <= 1'b0;
        end else if (push && illegal) begin
            err_q <= 1'b1;
        end
    end
    assign bus.err = err_q;
`else
    assign fifo_wdata = word;
    assign head_word  = fifo_rdata;
    assign head_drop  = 1'b0;
    assign bus.err    = 1'b0;
`endif

    instr_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign retire    = out_valid && !bus.mem_busy;
    assign out_free  = !out_valid || retire;
    assign head_load = !fifo_empty && !head_drop && out_free;
    assign pop       = head_load || head_drop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_LOAD;
            S_LOAD:  if (push && bus.in_last) state_d = S_DRAIN;
            S_DRAIN: if (fifo_empty && !out_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_DRAIN) && (state_d == S_IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            wd_q      <= '0;
            addr_q    <= '0;
            count_q   <= '0;
        end else begin
            if (state_q == S_IDLE && bus.start) begin
                addr_q  <= bus.base_addr;
                count_q <= '0;
            end else if (retire) begin
                addr_q <= addr_q + 1'b1;
                if (count_q != CNT_MAX) count_q <= count_q + 1'b1;
            end
            if (head_load) begin
                out_valid <= 1'b1;
                wd_q      <= head_word;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.mem_we   = out_valid;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.count    = count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: session sequencing, encoding, back-pressure,
// address wrap, illegal classes and reset during drain.
module tb_imem_loader;
    import instr_pkg::*;

    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [31:0]       wd_q[$];
    int                wc_q[$];

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.DEPTH(4), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset && bus.mem_we && !bus.mem_busy) begin
            wa_q.push_back(bus.mem_addr);
            wd_q.push_back(bus.mem_wd);
            wc_q.push_back(cyc);
        end
        if (bus.done) done_cnt++;
    end

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        bus.start = 1'b1;
        bus.base_addr = base;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tg, input logic last);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_kind = k; bus.in_rs = rs; bus.in_rt = rt; bus.in_rd = rd;
        bus.in_funct = fn; bus.in_imm = imm; bus.in_target = tg; bus.in_last = last;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic wait_done(input logic [ADDR_W:0] exp_count);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus.done !== 1'b1) begin
            miscompares++;
            $display("FAIL done_timeout: done=%b after %0d cycles, required 1", bus.done, n);
        end
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done: busy=%b required 0", bus.busy);
        end
        vectors++;
        if (bus.count !== exp_count) begin
            miscompares++;
            $display("FAIL count: count=%0d required %0d", bus.count, exp_count);
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || done_cnt != 1) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b pulses=%0d, required 0 and 1", bus.done, done_cnt);
        end
    endtask

    task automatic check_writes(input string tag, input logic [ADDR_W-1:0] ea[$], input logic [31:0] ed[$]);
        vectors++;
        if (wa_q.size() != ea.size()) begin
            miscompares++;
            $display("FAIL %s_nwrites: got %0d writes, required %0d", tag, wa_q.size(), ea.size());
        end else begin
            foreach (ea[i]) begin
                vectors++;
                if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
                    miscompares++;
                    $display("FAIL %s_write%0d: got %h@%h, required %h@%h", tag, i, wd_q[i], wa_q[i], ed[i], ea[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
        bus.in_kind = '0; bus.in_rs = '0; bus.in_rt = '0; bus.in_rd = '0;
        bus.in_funct = '0; bus.in_imm = '0; bus.in_target = '0; bus.mem_busy = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: ready/we/busy/done/err=%b required 00000",
                     {bus.in_ready, bus.mem_we, bus.busy, bus.done, bus.err});
        end
        vectors++;
        if (bus.mem_addr !== '0 || bus.mem_wd !== 32'h0 || bus.count !== '0) begin
            miscompares++;
            $display("FAIL reset_values: addr=%h wd=%h count=%0d required 0", bus.mem_addr, bus.mem_wd, bus.count);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h10);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL start_response: busy=%b in_ready=%b required 1 1", bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        send(3'd4, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0005, 26'd0, 1'b0);
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: mem_we=%b one cycle after accept, required 0", bus.mem_we);
        end
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_wd !== 32'h20020005 || bus.mem_addr !== 6'h10) begin
            miscompares++;
            $display("FAIL latency: we=%b wd=%h addr=%h required 1 20020005 10", bus.mem_we, bus.mem_wd, bus.mem_addr);
        end
        @(posedge clk); #1;
        send(3'd1, 5'd0, 5'd2, 5'd0, 6'd0, 16'h0050, 26'd0, 1'b1);
        wait_done(7'd2);
        ea = '{6'h10, 6'h11};
        ed = '{32'h20020005, 32'h8C020050};
        check_writes("basic", ea, ed);
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h20);
        send(3'd0, 5'd2, 5'd3, 5'd4, 6'h20, 16'h0, 26'd0, 1'b0);
        send(3'd5, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h11, 1'b0);
        send(3'd3, 5'd1, 5'd2, 5'd0, 6'h00, 16'h2, 26'd0, 1'b0);
        send(3'd2, 5'd0, 5'd7, 5'd0, 6'h00, 16'h54, 26'd0, 1'b1);
        wait_done(7'd4);
        ea = '{6'h20, 6'h21, 6'h22, 6'h23};
        ed = '{32'h00432020, 32'h08000011, 32'h10220002, 32'hAC070054};
        check_writes("b2b", ea, ed);
        vectors++;
        if (wc_q.size() != 4 || wc_q[3] - wc_q[0] != 3) begin
            miscompares++;
            $display("FAIL b2b_consecutive: %0d writes over span %0d, required 4 over 3",
                     wc_q.size(), wc_q.size() == 4 ? wc_q[3] - wc_q[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h00);
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'(i + 1), 26'd0, 1'b0);
        bus.in_valid = 1'b1; bus.in_kind = 3'd4; bus.in_imm = 16'd6;
        @(negedge clk);
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_full: in_ready=%b with FIFO full, required 0", bus.in_ready);
        end
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'h00 || bus.mem_wd !== 32'h20010001) begin
            miscompares++;
            $display("FAIL bp_hold1: we=%b addr=%h wd=%h required 1 00 20010001", bus.mem_we, bus.mem_addr, bus.mem_wd);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 6'h00 || bus.mem_wd !== 32'h20010001) begin
            miscompares++;
            $display("FAIL bp_hold2: we=%b addr=%h wd=%h required 1 00 20010001", bus.mem_we, bus.mem_addr, bus.mem_wd);
        end
        @(posedge clk); #1;
        bus.mem_busy = 1'b0;
        for (int i = 5; i < 8; i++) send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'(i + 1), 26'd0, i == 7);
        wait_done(7'd8);
        for (int i = 0; i < 8; i++) begin
            ea.push_back(6'(i));
            ed.push_back(32'h20010000 | 32'(i + 1));
        end
        check_writes("bp", ea, ed);
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h3F);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0001, 26'd0, 1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0002, 26'd0, 1'b1);
        wait_done(7'd2);
        ea = '{6'h3F, 6'h00};
        ed = '{32'h20010001, 32'h20010002};
        check_writes("wrap", ea, ed);
    endtask

    task automatic test_illegal();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h08);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0007, 26'd0, 1'b0);
        send(3'd6, 5'd3, 5'd3, 5'd3, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0008, 26'd0, 1'b1);
`ifdef IMEM_LOADER_CHECK_EN
        wait_done(7'd2);
        ea = '{6'h08, 6'h09};
        ed = '{32'h20010007, 32'h20010008};
        check_writes("illegal", ea, ed);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_err: err=%b required 1", bus.err);
        end
`else
        wait_done(7'd3);
        ea = '{6'h08, 6'h09, 6'h0A};
        ed = '{32'h20010007, 32'h00000000, 32'h20010008};
        check_writes("illegal", ea, ed);
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_err: err=%b required 0", bus.err);
        end
`endif
    endtask

    task automatic test_reset_drain();
        logic [ADDR_W-1:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        do_start(6'h30);
        bus.mem_busy = 1'b1;
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0011, 26'd0, 1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0012, 26'd0, 1'b0);
        send(3'd4, 5'd0, 5'd1, 5'd0, 6'd0, 16'h0013, 26'd0, 1'b1);
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1 || bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_pending: busy=%b we=%b ready=%b required 1 1 0", bus.busy, bus.mem_we, bus.in_ready);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({bus.mem_we, bus.busy, bus.done, bus.in_ready, bus.err} !== 5'b0 ||
            bus.mem_addr !== '0 || bus.mem_wd !== 32'h0 || bus.count !== '0) begin
            miscompares++;
            $display("FAIL reset_in_drain: we/busy/done/ready/err=%b addr=%h wd=%h count=%0d required all 0",
                     {bus.mem_we, bus.busy, bus.done, bus.in_ready, bus.err}, bus.mem_addr, bus.mem_wd, bus.count);
        end
        bus.mem_busy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        clear_log();
        do_start(6'h05);
        send(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0004, 26'd0, 1'b1);
        wait_done(7'd1);
        ea = '{6'h05};
        ed = '{32'hAC220004};
        check_writes("post_reset", ea, ed);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_illegal();
        test_reset_drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end
endmodule
